// File: rtl/phase_recover_pkg.sv
// Shared definitions for the phase_recover CORDIC block:
// size defaults, FSM state encoding and the arctangent table.
package phase_recover_pkg;

    localparam int W_DEF  = 48;
    localparam int PW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } state_t;

    // atan(2^-i) scaled so that a full turn is 2^16, rounded to nearest.
    function automatic logic [15:0] atan_entry(input int i);
        logic [15:0] v;
        v = 16'd0;
        case (i)
            0:       v = 16'd8192;
            1:       v = 16'd4836;
            2:       v = 16'd2555;
            3:       v = 16'd1297;
            4:       v = 16'd651;
            5:       v = 16'd326;
            6:       v = 16'd163;
            7:       v = 16'd81;
            8:       v = 16'd41;
            9:       v = 16'd20;
            10:      v = 16'd10;
            11:      v = 16'd5;
            12:      v = 16'd3;
            13:      v = 16'd1;
            14:      v = 16'd1;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/phase_recover_stage.sv
// One combinational vectoring-mode CORDIC micro-rotation.
// Ports: x_in/y_in/z_in current vector and angle, idx shift amount,
//        atan table value for idx; x_out/y_out/z_out next values.
module cordic_vec_stage
    import phase_recover_pkg::*;
#(
    parameter int XW = 50,
    parameter int PW = 16,
    parameter int CW = 4
) (
    input  logic signed [XW-1:0] x_in,
    input  logic signed [XW-1:0] y_in,
    input  logic        [PW-1:0] z_in,
    input  logic        [CW-1:0] idx,
    input  logic        [PW-1:0] atan,
    output logic signed [XW-1:0] x_out,
    output logic signed [XW-1:0] y_out,
    output logic        [PW-1:0] z_out
);

    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;

    assign x_sh = x_in >>> idx;
    assign y_sh = y_in >>> idx;

    // Rotate toward the x axis: the sign of y picks the direction,
    // and z tracks the angle rotated away (wraps modulo 2^PW).
    always_comb begin
        x_out = x_in;
        y_out = y_in;
        z_out = z_in;
        if (!y_in[XW-1]) begin
            x_out = x_in + y_sh;
            y_out = y_in - x_sh;
            z_out = z_in + atan;
        end else begin
            x_out = x_in - y_sh;
            y_out = y_in + x_sh;
            z_out = z_in - atan;
        end
    end

endmodule

// File: rtl/phase_recover.sv
// Iterative CORDIC phase recovery: atan2(g1, g0) as an unsigned PW-bit
// fraction of a full turn, one iteration per clock.
// Ports: clk, rst (sync, active high); in_valid/in_ready with g0 (cos)
//        and g1 (sin) in Q1.46; out_valid/out_ready with u1 (phase) and
//        zero (input vector was exactly zero).
module phase_recover
    import phase_recover_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  g0,
    input  logic [W-1:0]  g1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] u1,
    output logic          zero
);

    // Two guard bits cover negating -2^(W-1) and the CORDIC gain.
    localparam int XW = W + 2;
    localparam int CW = $clog2(PW);

    state_t state;
    state_t state_nx;

    logic signed [XW-1:0] x;
    logic signed [XW-1:0] y;
    logic        [PW-1:0] z;
    logic        [CW-1:0] cnt;
    logic                 is_zero;

    logic signed [XW-1:0] x_nx;
    logic signed [XW-1:0] y_nx;
    logic        [PW-1:0] z_nx;
    logic        [PW-1:0] atan_v;

    logic signed [XW-1:0] gx;
    logic signed [XW-1:0] gy;
    logic                 accept;
    logic                 last;

    assign gx     = {{2{g0[W-1]}}, g0};
    assign gy     = {{2{g1[W-1]}}, g1};
    assign accept = in_valid && in_ready;
    assign last   = (cnt == CW'(PW - 1));
    assign atan_v = PW'(atan_entry(int'(cnt)));

    cordic_vec_stage #(
        .XW (XW),
        .PW (PW),
        .CW (CW)
    ) u_stage (
        .x_in  (x),
        .y_in  (y),
        .z_in  (z),
        .idx   (cnt),
        .atan  (atan_v),
        .x_out (x_nx),
        .y_out (y_nx),
        .z_out (z_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (accept) begin
                    state_nx = ROTATE;
                end
            end
            ROTATE: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = !rst;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            z       <= '0;
            cnt     <= '0;
            is_zero <= 1'b0;
            u1      <= '0;
            zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        is_zero <= (g0 == '0) && (g1 == '0);
                        // Fold the left half-plane onto the right one
                        // by a half-turn rotation.
                        if (g0[W-1]) begin
                            x <= -gx;
                            y <= -gy;
                            z <= {1'b1, {(PW-1){1'b0}}};
                        end else begin
                            x <= gx;
                            y <= gy;
                            z <= '0;
                        end
                    end
                end
                ROTATE: begin
                    x   <= x_nx;
                    y   <= y_nx;
                    z   <= z_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        cnt  <= '0;
                        u1   <= is_zero ? '0 : z_nx;
                        zero <= is_zero;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_recover.sv
// Self-checking bench for phase_recover: directed corner cases,
// backpressure, mid-rotation reset and random vectors vs atan2.
module tb_phase_recover;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [47:0] g0;
    logic signed [47:0] g1;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        u1;
    logic               zero;

    int n_chk  = 0;
    int n_fail = 0;

    phase_recover dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g0        (g0),
        .g1        (g1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .u1        (u1),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    localparam logic signed [47:0] P46 = 48'h4000_0000_0000;
    localparam logic signed [47:0] N46 = 48'hC000_0000_0000;
    localparam logic signed [47:0] P45 = 48'h2000_0000_0000;
    localparam logic signed [47:0] N45 = 48'hE000_0000_0000;
    localparam logic signed [47:0] N47 = 48'h8000_0000_0000;
    localparam logic signed [47:0] N36 = 48'hFFF0_0000_0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Circular distance between two phase words, full turn = 65536.
    task automatic check_ang(input string tag, input logic [15:0] got,
                             input int exp);
        int d;
        d = ((int'(got) - exp) % 65536 + 65536) % 65536;
        if (d > 32768) d = 65536 - d;
        n_chk++;
        assert (d <= 2)
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d +/-2", tag, got, exp);
        end
    endtask

    // Ideal phase from the real-valued arctangent.
    function automatic int ref_u1(input logic signed [47:0] a,
                                  input logic signed [47:0] b);
        real ra;
        real rb;
        real v;
        int  r;
        ra = real'(longint'(a));
        rb = real'(longint'(b));
        v  = $atan2(rb, ra) * 65536.0 / (2.0 * 3.14159265358979);
        r  = $rtoi($floor(v + 0.5));
        return ((r % 65536) + 65536) % 65536;
    endfunction

    // Offer a pair, wait for acceptance and the result; returns the
    // result while out_valid is high (out_ready left to the caller).
    task automatic run_pair(input logic signed [47:0] a,
                            input logic signed [47:0] b,
                            output logic [15:0] ru, output logic rz);
        int w;
        int lat;
        g0 = a;
        g1 = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        check_eq("in_ready_wait", in_ready, 1);
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        check_eq("latency", lat, 16);
        ru = u1;
        rz = zero;
    endtask

    initial begin
        logic [15:0]        ru;
        logic               rz;
        logic [15:0]        held;
        logic [63:0]        t;
        logic signed [47:0] ra;
        logic signed [47:0] rb;
        int                 seen;
        real                mag;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        g0        = '0;
        g1        = '0;
        step();
        step();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_u1", u1, 0);
        check_eq("rst_zero", zero, 0);
        check_eq("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", in_ready, 1);

        run_pair(P46, 48'sd0, ru, rz);
        check_ang("ang_0", ru, 0);
        check_eq("zero_0", rz, 0);

        run_pair(48'sd0, P46, ru, rz);
        check_ang("ang_90", ru, 16384);

        run_pair(N46, 48'sd0, ru, rz);
        check_ang("ang_180", ru, 32768);

        run_pair(N47, 48'sd0, ru, rz);
        check_ang("ang_180_min", ru, 32768);

        run_pair(P46, N36, ru, rz);
        check_ang("ang_wrap", ru, 65526);

        run_pair(48'sd0, 48'sd0, ru, rz);
        check_eq("zero_flag", rz, 1);
        check_eq("zero_u1", ru, 0);

        // Backpressure: result must hold while out_ready is low.
        step();
        out_ready = 1'b0;
        run_pair(P45, N45, ru, rz);
        check_ang("ang_m45", ru, 57344);
        check_eq("bp_zero", rz, 0);
        held = ru;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("bp_u1_hold", u1, held);
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_out_valid", out_valid, 1);
        end
        // in_valid and out_ready together in DONE: release, no accept.
        g0        = 48'sd0;
        g1        = P45;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        check_eq("bp_release_valid", out_valid, 0);
        check_eq("bp_release_idle", in_ready, 1);
        run_pair(48'sd0, P45, ru, rz);
        check_ang("bp_second", ru, 16384);

        // Reset in the middle of the rotation.
        step();
        g0       = P46;
        g1       = P46;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        #1;
        check_eq("midrst_in_ready", in_ready, 0);
        check_eq("midrst_out_valid", out_valid, 0);
        step();
        rst = 1'b0;
        #1;
        check_eq("after_rst_in_ready", in_ready, 1);
        check_eq("after_rst_out_valid", out_valid, 0);
        seen = 0;
        repeat (20) begin
            step();
            if (out_valid) seen++;
        end
        check_eq("no_stale_result", seen, 0);
        run_pair(P45, P45, ru, rz);
        check_ang("ang_45", ru, 8192);

        // Random vectors with magnitude of at least 2^-8.
        for (int k = 0; k < 8; k++) begin
            ra  = '0;
            rb  = '0;
            mag = 0.0;
            for (int tries = 0; tries < 20 && mag < 274877906944.0; tries++) begin
                t   = {$urandom, $urandom};
                ra  = t[47:0];
                ra  = ra >>> $urandom_range(0, 8);
                t   = {$urandom, $urandom};
                rb  = t[47:0];
                rb  = rb >>> $urandom_range(0, 8);
                mag = $sqrt(real'(longint'(ra)) * real'(longint'(ra))
                          + real'(longint'(rb)) * real'(longint'(rb)));
            end
            if (mag < 274877906944.0) begin
                ra = P46;
                rb = N45;
            end
            step();
            run_pair(ra, rb, ru, rz);
            check_ang("rand_ang", ru, ref_u1(ra, rb));
            check_eq("rand_zero", rz, 0);
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_recover.md
PHASE_RECOVER -- requirements
Module: phase_recover

Interface
REQ-001 Parameter: W, 48, width of each signed input component.
REQ-002 Parameter: PW, 16, width of the recovered phase word; the iteration count equals PW.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  g0/g1 pair is valid.
REQ-006 Port: in_ready  output  1  block accepts a pair this cycle.
REQ-007 Port: g0  input  W  cosine component, signed two's complement Q1.46 (1.0 = 2^46).
REQ-008 Port: g1  input  W  sine component, same format as g0.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  downstream accepts the result.
REQ-011 Port: u1  output  PW  recovered phase, unsigned; angle = 2*pi*u1/2^PW.
REQ-012 Port: zero  output  1  input magnitude was exactly zero; u1 is forced to 0.

Function
REQ-013 Acceptance: a pair is accepted on an edge where in_valid and in_ready are both high.
REQ-014 FSM states: IDLE, ROTATE, DONE. IDLE->ROTATE on accept. ROTATE->DONE after PW iterations. DONE->IDLE on the edge where out_ready is high.
REQ-015 in_ready is high only in IDLE, and is low while rst is high. No accept occurs in DONE, even when out_ready and in_valid are high together.
REQ-016 Quadrant fold at accept:
- if g0<0: x=-g0, y=-g1, z=2^(PW-1);
- else: x=g0, y=g1, z=0.
REQ-017 x and y are held in W+2 bits (two guard bits), so that negating -2^(W-1) and the CORDIC gain of about 1.647 never overflow.
REQ-018 Iteration i (0..PW-1), vectoring mode:
- if y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i];
- else: the opposite signs.
- All shifts are arithmetic.
REQ-019 z accumulates modulo 2^PW, so wrap-around at 0/2^PW is natural. u1 = z at completion.
REQ-020 Latency: out_valid rises exactly PW cycles after the accepting edge. Throughput is one result per PW+2 cycles when out_ready is held high.
REQ-021 In DONE, u1 and zero stay stable while out_ready is low. out_valid falls on the edge where out_ready is high.
REQ-022 If g0==0 and g1==0: zero=1 and u1=0 with the same latency. Otherwise zero=0.
REQ-023 Accuracy: for input magnitude >= 2^-8, |u1 - round(atan2(g1,g0)*2^PW/(2*pi)) mod 2^PW| <= 2 LSB, measured circularly.

Reset
REQ-024 While rst is high, on each edge:
- state=IDLE, out_valid=0, u1=0, zero=0;
- x, y and z are cleared;
- iteration counter=0.
REQ-025 Reset asserted mid-ROTATE or in DONE abandons the operation. No result is produced for it, and in_ready returns high on the first cycle after rst falls.

Structure
REQ-026 A shared package holds:
- the ATAN table: PW entries, atan(2^-i)*2^PW/(2*pi) rounded to nearest, e.g. 8192, 4836, 2555, 1297, ...;
- the FSM state enum;
- the W and PW defaults.
REQ-027 One sub-module, cordic_vec_stage, holds the combinational single-iteration add/shift/select. It is instantiated once and fed the iteration counter; the parent holds the registers and the FSM.

Verification
REQ-028 Reset, then g0=2^46, g1=0 -> u1 in {65534..65535, 0..2}, zero=0, out_valid exactly 16 cycles after accept.
REQ-029 Three cases:
- g0=0, g1=2^46 -> u1=16384+/-2;
- g0=-2^46, g1=0 -> u1=32768+/-2;
- g0=-2^47 (most negative), g1=0 -> u1=32768+/-2 with no overflow.
REQ-030 Wrap-around: g0=2^46, g1=-2^36 -> u1=65526+/-2.
REQ-031 g0=0, g1=0 -> zero=1, u1=0.
REQ-032 Backpressure, checked as follows:
- hold out_ready low for 5 cycles after out_valid: u1 stays stable and in_ready=0;
- assert out_ready: the state returns to IDLE on the next edge;
- a second pair is then accepted and its result is correct.
REQ-033 Reset during ROTATE: assert rst at iteration 8 for 1 cycle.
- out_valid=0 follows and no stale result appears.
- in_ready is high the cycle after rst falls.
- The next pair g0=g1=2^45 gives u1=8192+/-2.
